// File: rtl/alu_seq_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, legal-op list, FSM states.
// Helpers classify opcodes for the top-level decoder.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    LSH = 4'b0000,
    RSH = 4'b0001,
    AND = 4'b0010,
    OR  = 4'b0011,
    MUL = 4'b0100,
    GEQ = 4'b1000,
    EQ  = 4'b1001,
    NEG = 4'b1010,
    ADD = 4'b1011,
    NEQ = 4'b1101
  } op_t;

  localparam int N_LEGAL = 10;
  localparam op_t LEGAL_OPS [N_LEGAL] = '{
    LSH, RSH, AND, OR, MUL, GEQ, EQ, NEG, ADD, NEQ
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  function automatic logic is_legal(op_t op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_LEGAL; i++)
      if (op == LEGAL_OPS[i]) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic is_iter(op_t op);
    return (op == LSH) || (op == RSH) || (op == MUL);
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative datapath: one-bit-per-cycle shifter and shift-add multiplier.
// Next-step values are exposed so the top can capture the final step.
module alu_iter_unit
  import alu_seq_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  op_t          load_op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         step,
  input  op_t          op,
  output logic         last,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         carry
);

  localparam int CW = SHW + 1;

  logic [W-1:0]  lo_q;
  logic [W-1:0]  hi_q;
  logic [W-1:0]  mc_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    sum;

  // Product sits in {hi,lo}; lo starts as the multiplier and drains right.
  always_comb begin
    lo    = lo_q;
    hi    = hi_q;
    carry = 1'b0;
    sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mc_q : {W{1'b0}})};
    case (op)
      LSH: if (cnt_q != '0) {carry, lo} = {lo_q, 1'b0};
      RSH: if (cnt_q != '0) {lo, carry} = {1'b0, lo_q};
      MUL: {hi, lo} = {sum, lo_q[W-1:1]};
      default: ;
    endcase
  end

  assign last = (cnt_q <= CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q  <= '0;
      hi_q  <= '0;
      mc_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      lo_q <= (load_op == MUL) ? b : a;
      hi_q <= '0;
      mc_q <= a;
      if (load_op == MUL)
        cnt_q <= CW'(W);
      else if (load_op == LSH || load_op == RSH)
        cnt_q <= {1'b0, b[SHW-1:0]};
      else
        cnt_q <= '0;
    end else if (step) begin
      lo_q <= lo;
      hi_q <= hi;
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU top: Start/Ready/Done FSM, single-step ops and
// registered result/flag outputs that change only when Done rises.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  op_t          OP,
  input  logic [W-1:0] InputA,
  input  logic [W-1:0] InputB,
  output logic         Ready,
  output logic         Done,
  output logic [W-1:0] Out,
  output logic [W-1:0] OutHi,
  output logic         Zero,
  output logic         Carry,
  output logic         Illegal
);

  localparam int SHW = $clog2(W);

  alu_state_t   state;
  alu_state_t   state_nxt;
  op_t          op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         accept;
  logic         run;
  logic         fin;
  logic         it_last;
  logic [W-1:0] it_lo;
  logic [W-1:0] it_hi;
  logic         it_c;
  logic [W-1:0] res;
  logic [W-1:0] res_hi;
  logic         res_c;
  logic         res_ill;

  assign Ready  = (state != RUN);
  assign Done   = (state == DONE);
  assign accept = Start && Ready;
  assign run    = (state == RUN);
  assign fin    = is_iter(op_q) ? it_last : 1'b1;

  alu_iter_unit #(.W(W), .SHW(SHW)) u_iter (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .load    (accept),
    .load_op (OP),
    .a       (InputA),
    .b       (InputB),
    .step    (run),
    .op      (op_q),
    .last    (it_last),
    .lo      (it_lo),
    .hi      (it_hi),
    .carry   (it_c)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (fin) state_nxt = DONE;
      DONE:    state_nxt = Start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      op_q <= LSH;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= OP;
      a_q  <= InputA;
      b_q  <= InputB;
    end
  end

  always_comb begin
    res     = '0;
    res_hi  = '0;
    res_c   = 1'b0;
    res_ill = !is_legal(op_q);
    case (op_q)
      LSH, RSH: begin
        res   = it_lo;
        res_c = it_c;
      end
      AND: res = a_q & b_q;
      OR:  res = a_q | b_q;
      MUL: begin
        res    = it_lo;
        res_hi = it_hi;
      end
      GEQ: res = W'(a_q >= b_q);
      EQ:  res = W'(a_q == b_q);
      NEG: res = ~a_q + W'(1);
      ADD: {res_c, res} = {1'b0, a_q} + {1'b0, b_q};
      NEQ: res = W'(a_q != b_q);
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Out     <= '0;
      OutHi   <= '0;
      Zero    <= 1'b1;
      Carry   <= 1'b0;
      Illegal <= 1'b0;
    end else if (run && fin) begin
      Out     <= res;
      OutHi   <= res_hi;
      Zero    <= (res == '0);
      Carry   <= res_c;
      Illegal <= res_ill;
    end
  end

endmodule
